// File: rtl/elevator_pkg.sv
// Shared types and register map for the SCAN elevator controller.
// Holds the FSM state encoding, register word offsets and STATUS bit positions.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    localparam logic [1:0] REQ_ADDR    = 2'd0;
    localparam logic [1:0] CLR_ADDR    = 2'd1;
    localparam logic [1:0] STATUS_ADDR = 2'd2;

    localparam int STAT_DIR_BIT    = 8;
    localparam int STAT_DOOR_BIT   = 9;
    localparam int STAT_MOVING_BIT = 10;
    localparam int STAT_STATE_LSB  = 16;

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter that holds at zero; used for both travel and door timing.
// A load strobe takes priority over counting.
module elevator_timer
    import elevator_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, decrement, or hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator controller with a pending-request bitmap fed by call
// buttons and a memory-mapped REQ/CLR/STATUS register port.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = $clog2(FLOORS),
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 6,
    parameter int DATA_W      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [FLOORS-1:0]  i_call,
    input  logic               i_we,
    input  logic [1:0]         i_addr,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_rdata,
    output logic [FLOOR_W-1:0] o_floor,
    output logic               o_dir,
    output logic               o_moving,
    output logic               o_door_open,
    output logic               o_arrive,
    output logic [FLOORS-1:0]  o_pending
);

    localparam int MT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_q, dir_d;
    logic [FLOORS-1:0]    pending_q, pending_d;
    logic                 arrive_q, arrive_d;

    logic [FLOORS-1:0]    set_s, clr_s, arr_clr_s, absorb_s, req_s;
    logic [FLOOR_W-1:0]   step_floor_s;
    logic                 up_s, dn_s, step_up_s, step_dn_s, new_here_s;
    logic                 mv_load_s, mv_zero_s, dr_load_s, dr_zero_s;
    logic [DATA_W-1:0]    status_s;
    logic                 unused_wdata_s;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i > int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i < int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    assign unused_wdata_s = ^i_wdata;

    // Register-port decode and request terms; a door already open here absorbs new calls.
    always_comb begin
        set_s      = (i_we && (i_addr == REQ_ADDR)) ? i_wdata[FLOORS-1:0] : {FLOORS{1'b0}};
        clr_s      = (i_we && (i_addr == CLR_ADDR)) ? i_wdata[FLOORS-1:0] : {FLOORS{1'b0}};
        req_s      = set_s | i_call;
        absorb_s   = (state_q == ST_DOOR) ? (FLOORS'(1) << floor_q) : {FLOORS{1'b0}};
        new_here_s = (state_q == ST_DOOR) && req_s[floor_q];
        step_floor_s = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
        up_s       = any_above(pending_q, floor_q);
        dn_s       = any_below(pending_q, floor_q);
        step_up_s  = any_above(pending_q, step_floor_s);
        step_dn_s  = any_below(pending_q, step_floor_s);
    end

    // SCAN scheduler next-state logic.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        arrive_d  = 1'b0;
        arr_clr_s = {FLOORS{1'b0}};
        mv_load_s = 1'b0;
        dr_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d            = ST_DOOR;
                    arr_clr_s[floor_q] = 1'b1;
                    arrive_d           = 1'b1;
                    dr_load_s          = 1'b1;
                end else if (dir_q ? up_s : dn_s) begin
                    state_d   = ST_MOVE;
                    mv_load_s = 1'b1;
                end else if (dir_q ? dn_s : up_s) begin
                    dir_d     = ~dir_q;
                    state_d   = ST_MOVE;
                    mv_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (mv_zero_s) begin
                    floor_d = step_floor_s;
                    if (pending_q[step_floor_s]) begin
                        state_d                 = ST_DOOR;
                        arr_clr_s[step_floor_s] = 1'b1;
                        arrive_d                = 1'b1;
                        dr_load_s               = 1'b1;
                    end else if (dir_q ? step_up_s : step_dn_s) begin
                        mv_load_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_DOOR: begin
                if (new_here_s) begin
                    dr_load_s = 1'b1;
                end else if (dr_zero_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DOOR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pending_d = (pending_q & ~clr_s & ~arr_clr_s) | (req_s & ~absorb_s);
    end

    // Architectural state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            floor_q   <= {FLOOR_W{1'b0}};
            dir_q     <= 1'b1;
            pending_q <= {FLOORS{1'b0}};
            arrive_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            arrive_q  <= arrive_d;
        end
    end

    elevator_timer #(.W(MT_W)) u_move_tmr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (mv_load_s),
        .i_load_val (MT_W'(MOVE_CYCLES - 1)),
        .o_zero     (mv_zero_s)
    );

    elevator_timer #(.W(DT_W)) u_door_tmr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (dr_load_s),
        .i_load_val (DT_W'(DOOR_CYCLES - 1)),
        .o_zero     (dr_zero_s)
    );

    // Read mux; STATUS packs position, direction and FSM state.
    always_comb begin
        status_s                               = {DATA_W{1'b0}};
        status_s[FLOOR_W-1:0]                  = floor_q;
        status_s[STAT_DIR_BIT]                 = dir_q;
        status_s[STAT_DOOR_BIT]                = (state_q == ST_DOOR);
        status_s[STAT_MOVING_BIT]              = (state_q == ST_MOVE);
        status_s[STAT_STATE_LSB +: 2]          = state_q;
        case (i_addr)
            REQ_ADDR:    o_rdata = DATA_W'(pending_q);
            CLR_ADDR:    o_rdata = {DATA_W{1'b0}};
            STATUS_ADDR: o_rdata = status_s;
            default:     o_rdata = {DATA_W{1'b0}};
        endcase
    end

    assign o_floor     = floor_q;
    assign o_dir       = dir_q;
    assign o_moving    = (state_q == ST_MOVE);
    assign o_door_open = (state_q == ST_DOOR);
    assign o_arrive    = arrive_q;
    assign o_pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl: a vector table for the pending
// bitmap and register port, plus hand-written multi-cycle scheduling sequences.
module tb_elevator_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  call;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  floor;
    logic        dir, moving, door_open, arrive;
    logic [7:0]  pending;

    int checks = 0;
    int failures = 0;
    int arrive_cnt = 0;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  call;
        logic [7:0]  exp_pend;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] exp_q [$];
    logic [2:0] stop_q [$];

    elevator_scan_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_call      (call),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_floor     (floor),
        .o_dir       (dir),
        .o_moving    (moving),
        .o_door_open (door_open),
        .o_arrive    (arrive),
        .o_pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arrive) arrive_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; addr = 2'd0; wdata = 32'd0; call = 8'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; addr = 2'd0; wdata = 32'd0;
    endtask

    task automatic wait_floor(input logic [2:0] f, input int budget);
        int n;
        n = 0;
        while (floor !== f && n < budget) begin
            tick();
            n++;
        end
        check("wait_floor", {29'd0, floor}, {29'd0, f});
    endtask

    task automatic count_door_open(output int n);
        n = 0;
        while (door_open === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int a0;
        logic [2:0] drop_floor;
        logic [7:0] e;

        idle_inputs();
        rst_n = 1'b1;

        // Test 1: reset state.
        a0 = arrive_cnt;
        do_reset();
        addr = 2'd2; #1;
        check("rst_floor", {29'd0, floor}, 32'd0);
        check("rst_dir", {31'd0, dir}, 32'd1);
        check("rst_status", rdata, 32'h100);
        check("rst_pending", {24'd0, pending}, 32'd0);
        check("rst_moving_door", {30'd0, moving, door_open}, 32'd0);
        repeat (20) tick();
        check("rst_no_arrive", arrive_cnt - a0, 32'd0);
        addr = 2'd0;

        // Pending-bitmap vector table, driven one per cycle from floor 0.
        vecs[0] = '{1'b1, 2'd0, 32'h30,  8'h00, 8'h30};
        vecs[1] = '{1'b1, 2'd1, 32'h10,  8'h00, 8'h20};
        vecs[2] = '{1'b1, 2'd1, 32'h20,  8'h20, 8'h20};
        vecs[3] = '{1'b1, 2'd1, 32'h20,  8'h00, 8'h00};
        vecs[4] = '{1'b1, 2'd0, 32'hF04, 8'h00, 8'h04};
        vecs[5] = '{1'b1, 2'd2, 32'hFF,  8'h00, 8'h04};
        vecs[6] = '{1'b0, 2'd0, 32'h00,  8'h80, 8'h84};
        vecs[7] = '{1'b1, 2'd1, 32'hFF,  8'h00, 8'h00};
        vecs[8] = '{1'b1, 2'd0, 32'h02,  8'h00, 8'h02};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata; call = vecs[i].call;
            exp_q.push_back(vecs[i].exp_pend);
            tick();
            idle_inputs();
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d_pending", i), {24'd0, pending}, {24'd0, e});
            check($sformatf("vec%0d_rdata", i), rdata, {24'd0, e});
        end
        addr = 2'd1; #1;
        check("clr_reads_zero", rdata, 32'd0);
        addr = 2'd0;

        // Test 2: single trip 0 -> 3.
        do_reset();
        a0 = arrive_cnt;
        write(2'd0, 32'h08);
        check("t2_pending_1cyc", {24'd0, pending}, 32'h08);
        check("t2_not_moving_yet", {31'd0, moving}, 32'd0);
        tick();
        check("t2_moving_2edges", {31'd0, moving}, 32'd1);
        repeat (3) tick();
        check("t2_floor_hold", {29'd0, floor}, 32'd0);
        tick();
        check("t2_step_period", {29'd0, floor}, 32'd1);
        repeat (8) tick();
        check("t2_floor3", {29'd0, floor}, 32'd3);
        check("t2_arrive", {31'd0, arrive}, 32'd1);
        check("t2_door", {31'd0, door_open}, 32'd1);
        count_door_open(n);
        check("t2_door_cycles", n, 32'd6);
        check("t2_arrive_once", arrive_cnt - a0, 32'd1);
        addr = 2'd2; #1;
        check("t2_status_idle", rdata, 32'h103);
        check("t2_pending_empty", {24'd0, pending}, 32'd0);
        addr = 2'd0;

        // Test 3: SCAN order 4, 6, then reverse to 1.
        do_reset();
        write(2'd0, 32'h40);
        wait_floor(3'd2, 40);
        check("t3_moving_up", {30'd0, moving, dir}, 32'd3);
        stop_q.push_back(3'd4);
        stop_q.push_back(3'd6);
        stop_q.push_back(3'd1);
        write(2'd0, 32'h12);
        drop_floor = 3'd7;
        n = 0;
        while (stop_q.size() != 0 && n < 300) begin
            if (arrive === 1'b1) check("t3_stop_order", {29'd0, floor}, {29'd0, stop_q.pop_front()});
            if (dir === 1'b0 && drop_floor == 3'd7) drop_floor = floor;
            tick();
            n++;
        end
        check("t3_stops_left", stop_q.size(), 32'd0);
        check("t3_dir_drop_floor", {29'd0, drop_floor}, 32'd6);

        // Test 4: call at current floor while door open extends it.
        do_reset();
        a0 = arrive_cnt;
        write(2'd0, 32'h08);
        n = 0;
        while (arrive !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("t4_arrived_floor3", {29'd0, floor}, 32'd3);
        repeat (4) tick();
        call = 8'h08;
        tick();
        call = 8'h00;
        check("t4_pending_absorbed", {24'd0, pending}, 32'd0);
        count_door_open(n);
        check("t4_door_extended", n, 32'd6);
        check("t4_single_arrive", arrive_cnt - a0, 32'd1);

        // Test 5: cancel during MOVE; call beats clear on the same bit.
        do_reset();
        write(2'd0, 32'h20);
        write(2'd1, 32'h20);
        check("t5_moving", {31'd0, moving}, 32'd1);
        check("t5_cleared", {24'd0, pending}, 32'd0);
        wait_floor(3'd1, 20);
        check("t5_idle_after_step", {31'd0, moving}, 32'd0);
        repeat (6) tick();
        check("t5_floor_hold", {29'd0, floor}, 32'd1);
        call = 8'h20;
        write(2'd1, 32'h20);
        call = 8'h00;
        check("t5_set_wins", {24'd0, pending}, 32'h20);

        // Test 6: asynchronous reset mid-move.
        do_reset();
        write(2'd0, 32'h80);
        wait_floor(3'd4, 40);
        check("t6_moving", {31'd0, moving}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        addr = 2'd2; #0.5;
        check("t6_async_floor", {29'd0, floor}, 32'd0);
        check("t6_async_state", {29'd0, moving, door_open, dir}, 32'd1);
        check("t6_async_pending", {24'd0, pending}, 32'd0);
        check("t6_async_status", rdata, 32'h100);
        addr = 2'd0;
        #1 rst_n = 1'b1;
        tick();
        write(2'd0, 32'h01);
        check("t6_req0_pending", {24'd0, pending}, 32'h01);
        tick();
        check("t6_door_at_0", {29'd0, floor}, 32'd0);
        check("t6_open_arrive", {30'd0, door_open, arrive}, 32'd3);
        check("t6_no_motion", {31'd0, moving}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
